// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
// Imported by the LSU top, its alignment helper and the bus interface.
package mem_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory bus between the LSU (master) and memory (slave).
// Signal names keep the LSU-side direction suffix.
interface mem_lsu_if;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o,
        output mem_wdata_o, mem_be_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o,
        input  mem_wdata_o, mem_be_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store enables/replication and load extraction
// with sign or zero extension.
module lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        if (funct3_i[1]) begin
            be_o    = 4'b1111;
            wdata_o = wdata_i;
        end else if (funct3_i[0]) begin
            be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
            wdata_o = {2{wdata_i[15:0]}};
        end else begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
        end
    end

    always_comb begin
        byte_v = rdata_i[7:0];
        unique case (addr_lo_i)
            2'd0: byte_v = rdata_i[7:0];
            2'd1: byte_v = rdata_i[15:8];
            2'd2: byte_v = rdata_i[23:16];
            2'd3: byte_v = rdata_i[31:24];
        endcase
    end

    assign half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        rdata_o = rdata_i;
        case (funct3_i)
            F3_LB:   rdata_o = {{24{byte_v[7]}}, byte_v};
            F3_LH:   rdata_o = {{16{half_v[15]}}, half_v};
            F3_LBU:  rdata_o = {24'h0, byte_v};
            F3_LHU:  rdata_o = {16'h0, half_v};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: runs one EX/MEM access on the
// req/gnt/rvalid bus and stalls the pipeline until it completes.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    mem_lsu_if.master   bus,
    output logic        stall_o,
    output logic [31:0] data_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_e      state_q, state_d;
    logic [31:0] addr_q;
    logic [2:0]  f3_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        kill_q, kill_d;

    logic        acc, is_st, mis, launch;
    logic        wd_hit, done_hit, err, upd;
    logic [1:0]  sel_lo;
    logic [2:0]  sel_f3;
    logic [3:0]  be_st;
    logic [31:0] wd_rep, ld_fmt;

    assign acc    = (MemRead_i | MemWrite_i) & ~flush_i;
    assign is_st  = MemWrite_i & ~MemRead_i;
    assign mis    = funct3_i[1] ? (addr_i[1:0] != 2'b00)
                                : (funct3_i[0] & addr_i[0]);
    assign launch = (state_q == IDLE) & acc & ~mis;

    // Stores are steered from live inputs; loads from the latched request.
    assign sel_lo = (state_q == IDLE) ? addr_i[1:0] : addr_q[1:0];
    assign sel_f3 = (state_q == IDLE) ? funct3_i : f3_q;

    lsu_align u_align (
        .addr_lo_i (sel_lo),
        .funct3_i  (sel_f3),
        .wdata_i   (wdata_i),
        .rdata_i   (bus.mem_rdata_i),
        .be_o      (be_st),
        .wdata_o   (wd_rep),
        .rdata_o   (ld_fmt)
    );

    assign wd_hit = (TIMEOUT_CYC != 0) &&
                    (cnt_q == CW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        kill_d   = kill_q;
        done_hit = 1'b0;
        err      = 1'b0;
        unique case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (launch) state_d = REQ;
            end
            REQ: begin
                cnt_d  = cnt_q + CW'(1);
                kill_d = kill_q | (bus.mem_gnt_i & flush_i);
                if (bus.mem_gnt_i && bus.mem_rvalid_i) begin
                    state_d  = DONE;
                    done_hit = 1'b1;
                end else if (flush_i && !bus.mem_gnt_i) begin
                    state_d = IDLE;
                end else if (wd_hit) begin
                    state_d = DONE;
                    err     = 1'b1;
                end else if (bus.mem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d  = cnt_q + CW'(1);
                kill_d = kill_q | flush_i;
                if (bus.mem_rvalid_i) begin
                    state_d  = DONE;
                    done_hit = 1'b1;
                end else if (wd_hit) begin
                    state_d = DONE;
                    err     = 1'b1;
                end
            end
            DONE: state_d = IDLE;
        endcase
    end

    // A squashed access still finishes on the bus but never writes data_o.
    assign upd    = (done_hit | err) & ~we_q & ~kill_q & ~flush_i;
    assign data_d = err ? 32'h0 : ld_fmt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kill_q  <= kill_d;
            if (launch) begin
                addr_q  <= addr_i;
                f3_q    <= funct3_i;
                we_q    <= is_st;
                be_q    <= is_st ? be_st : 4'b1111;
                wdata_q <= wd_rep;
            end
            if (upd) data_q <= data_d;
        end
    end

    assign bus.mem_req_o   = (state_q == REQ);
    assign bus.mem_we_o    = we_q;
    assign bus.mem_addr_o  = {addr_q[31:2], 2'b00};
    assign bus.mem_wdata_o = wdata_q;
    assign bus.mem_be_o    = be_q;

    assign stall_o    = launch | (state_q == REQ) | (state_q == WAIT);
    assign data_o     = data_q;
    assign misalign_o = (state_q == IDLE) & acc & mis;
    assign bus_err_o  = err;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: vector table with a load-data
// scoreboard plus hand sequences for flush, watchdog and reset.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        rd0, wr0, fl0, stall0, mis0, err0;
    logic [2:0]  f30;
    logic [31:0] ad0, wd0, data0;
    logic        rd1, wr1, fl1, stall1, mis1, err1;
    logic [2:0]  f31;
    logic [31:0] ad1, wd1, data1;

    mem_lsu_if b0();
    mem_lsu_if b1();

    mem_lsu u_dut (
        .clk(clk), .rst_n(rst_n),
        .MemRead_i(rd0), .MemWrite_i(wr0), .funct3_i(f30),
        .addr_i(ad0), .wdata_i(wd0), .flush_i(fl0),
        .bus(b0),
        .stall_o(stall0), .data_o(data0),
        .misalign_o(mis0), .bus_err_o(err0)
    );

    mem_lsu #(.TIMEOUT_CYC(4)) u_wd (
        .clk(clk), .rst_n(rst_n),
        .MemRead_i(rd1), .MemWrite_i(wr1), .funct3_i(f31),
        .addr_i(ad1), .wdata_i(wd1), .flush_i(fl1),
        .bus(b1),
        .stall_o(stall1), .data_o(data1),
        .misalign_o(mis1), .bus_err_o(err1)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gd;
        int          rv;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic        e_we;
        logic [31:0] e_wd;
        logic [31:0] e_data;
    } vec_t;

    vec_t        vt[14];
    logic [31:0] sb_q[$];
    logic [31:0] held;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int stalls, reqc, waitc;
        bit granted, done, unstable;
        logic [31:0] e;
        stalls = 0; reqc = 0; waitc = 0;
        granted = 0; done = 0; unstable = 0;
        @(negedge clk);
        rd0 = v.rd; wr0 = v.wr; f30 = v.f3;
        ad0 = v.addr; wd0 = v.wdata;
        sb_q.push_back(v.e_data);
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            b0.mem_gnt_i = 1'b0;
            b0.mem_rvalid_i = 1'b0;
            if (c > 0 && !stall0) begin
                done = 1;
                rd0 = 1'b0; wr0 = 1'b0;
                e = sb_q.pop_front();
                chk($sformatf("v%0d_data", idx), data0, e);
                held = e;
            end else begin
                if (stall0) stalls++;
                if (b0.mem_req_o) begin
                    if (reqc == 0) begin
                        chk($sformatf("v%0d_addr", idx),
                            b0.mem_addr_o, v.e_addr);
                        chk($sformatf("v%0d_be", idx),
                            {28'h0, b0.mem_be_o}, {28'h0, v.e_be});
                        chk($sformatf("v%0d_we", idx),
                            {31'h0, b0.mem_we_o}, {31'h0, v.e_we});
                        if (v.e_we)
                            chk($sformatf("v%0d_wdata", idx),
                                b0.mem_wdata_o, v.e_wd);
                    end else if (b0.mem_addr_o !== v.e_addr ||
                                 b0.mem_be_o !== v.e_be) begin
                        unstable = 1;
                    end
                    if (reqc == v.gd) begin
                        b0.mem_gnt_i = 1'b1;
                        granted = 1;
                        if (v.rv == 0) begin
                            b0.mem_rvalid_i = 1'b1;
                            b0.mem_rdata_i = v.rdata;
                        end
                    end
                    reqc++;
                end else if (granted) begin
                    waitc++;
                    if (waitc == v.rv) begin
                        b0.mem_rvalid_i = 1'b1;
                        b0.mem_rdata_i = v.rdata;
                    end
                end
            end
            if (!done) @(negedge clk);
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL v%0d_timeout actual=busy required=done", idx);
            void'(sb_q.pop_front());
            rd0 = 1'b0; wr0 = 1'b0;
        end
        chk($sformatf("v%0d_stall", idx), stalls, 2 + v.gd + v.rv);
        chk($sformatf("v%0d_reqcyc", idx), reqc, v.gd + 1);
        if (v.gd > 0)
            chk($sformatf("v%0d_req_stable", idx), {31'h0, unstable}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rd0 = 0; wr0 = 0; fl0 = 0; f30 = 0; ad0 = 0; wd0 = 0;
        rd1 = 0; wr1 = 0; fl1 = 0; f31 = 0; ad1 = 0; wd1 = 0;
        b0.mem_gnt_i = 0; b0.mem_rvalid_i = 0; b0.mem_rdata_i = 0;
        b1.mem_gnt_i = 0; b1.mem_rvalid_i = 0; b1.mem_rdata_i = 0;
        held = 32'h0;

        //        rd wr f3     addr      wdata     rdata     gd rv eaddr     be    we ewd       edata
        vt[0]  = '{1, 0, F3_LW,  32'h100, 32'h0,     32'hDEADBEEF, 0, 0, 32'h100, 4'hF, 0, 32'h0,     32'hDEADBEEF};
        vt[1]  = '{1, 0, F3_LB,  32'h103, 32'h0,     32'h80FF1234, 0, 0, 32'h100, 4'hF, 0, 32'h0,     32'hFFFFFF80};
        vt[2]  = '{1, 0, F3_LBU, 32'h103, 32'h0,     32'h80FF1234, 0, 0, 32'h100, 4'hF, 0, 32'h0,     32'h00000080};
        vt[3]  = '{1, 0, F3_LHU, 32'h102, 32'h0,     32'h80FF1234, 0, 0, 32'h100, 4'hF, 0, 32'h0,     32'h000080FF};
        vt[4]  = '{0, 1, F3_LH,  32'h206, 32'h1234ABCD, 32'h0,     0, 0, 32'h204, 4'hC, 1, 32'hABCDABCD, 32'h000080FF};
        vt[5]  = '{1, 0, F3_LH,  32'h102, 32'h0,     32'h80FF1234, 1, 1, 32'h100, 4'hF, 0, 32'h0,     32'hFFFF80FF};
        vt[6]  = '{0, 1, F3_LB,  32'h101, 32'h000000A5, 32'h0,     0, 1, 32'h100, 4'h2, 1, 32'hA5A5A5A5, 32'hFFFF80FF};
        vt[7]  = '{1, 0, F3_LW,  32'h104, 32'h0,     32'h12345678, 3, 2, 32'h104, 4'hF, 0, 32'h0,     32'h12345678};
        vt[8]  = '{0, 1, F3_LW,  32'h308, 32'hCAFEF00D, 32'h0,     2, 0, 32'h308, 4'hF, 1, 32'hCAFEF00D, 32'h12345678};
        vt[9]  = '{1, 0, F3_LB,  32'h100, 32'h0,     32'h0000007F, 0, 0, 32'h100, 4'hF, 0, 32'h0,     32'h0000007F};
        vt[10] = '{1, 1, F3_LW,  32'h010, 32'h11111111, 32'h55AA55AA, 0, 0, 32'h010, 4'hF, 0, 32'h0,  32'h55AA55AA};
        vt[11] = '{1, 0, F3_LHU, 32'h100, 32'h0,     32'hFFFF8001, 0, 0, 32'h100, 4'hF, 0, 32'h0,     32'h00008001};
        vt[12] = '{0, 1, F3_LB,  32'h103, 32'h12345677, 32'h0,     0, 0, 32'h100, 4'h8, 1, 32'h77777777, 32'h00008001};
        vt[13] = '{1, 0, F3_LH,  32'h100, 32'h0,     32'h00007FFF, 0, 0, 32'h100, 4'hF, 0, 32'h0,     32'h00007FFF};

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", {31'h0, b0.mem_req_o}, 0);
        chk("rst_we", {31'h0, b0.mem_we_o}, 0);
        chk("rst_addr", b0.mem_addr_o, 0);
        chk("rst_wdata", b0.mem_wdata_o, 0);
        chk("rst_be", {28'h0, b0.mem_be_o}, 0);
        chk("rst_data", data0, 0);
        chk("rst_stall", {31'h0, stall0}, 0);
        chk("rst_err", {31'h0, err0}, 0);
        chk("rst_wd_data", data1, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run_vec(i, vt[i]);

        // misaligned accesses never reach the bus
        @(negedge clk);
        rd0 = 1; f30 = F3_LW; ad0 = 32'h102;
        #1;
        chk("mis_lw", {31'h0, mis0}, 1);
        chk("mis_lw_stall", {31'h0, stall0}, 0);
        begin
            bit req_seen;
            req_seen = 0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk); #1;
                if (b0.mem_req_o || stall0) req_seen = 1;
            end
            chk("mis_no_req", {31'h0, req_seen}, 0);
        end
        chk("mis_data_held", data0, held);
        rd0 = 0; wr0 = 1; f30 = F3_LH; ad0 = 32'h301;
        #1;
        chk("mis_sh", {31'h0, mis0}, 1);
        fl0 = 1;
        #1;
        chk("mis_flushed", {31'h0, mis0}, 0);
        wr0 = 0; fl0 = 0;

        // flush in REQ before gnt: back to IDLE, no DONE
        @(negedge clk);
        rd0 = 1; f30 = F3_LW; ad0 = 32'h200;
        @(negedge clk); #1;
        chk("flreq_req", {31'h0, b0.mem_req_o}, 1);
        fl0 = 1;
        @(negedge clk); #1;
        chk("flreq_idle_req", {31'h0, b0.mem_req_o}, 0);
        chk("flreq_idle_stall", {31'h0, stall0}, 0);
        rd0 = 0; fl0 = 0;
        b0.mem_rvalid_i = 1; b0.mem_rdata_i = 32'hBAD0BAD0;
        @(negedge clk); #1;
        b0.mem_rvalid_i = 0;
        chk("flreq_data_held", data0, held);
        chk("flreq_stall_after", {31'h0, stall0}, 0);

        // flush in WAIT: transaction finishes, data_o untouched
        @(negedge clk);
        rd0 = 1; f30 = F3_LB; ad0 = 32'h103;
        @(negedge clk); #1;
        chk("flwait_req", {31'h0, b0.mem_req_o}, 1);
        b0.mem_gnt_i = 1;
        @(negedge clk); #1;
        b0.mem_gnt_i = 0;
        chk("flwait_stall", {31'h0, stall0}, 1);
        fl0 = 1;
        b0.mem_rvalid_i = 1; b0.mem_rdata_i = 32'h80000000;
        @(negedge clk); #1;
        b0.mem_rvalid_i = 0;
        chk("flwait_done", {31'h0, stall0}, 0);
        rd0 = 0; fl0 = 0;
        chk("flwait_data_held", data0, held);

        // watchdog (TIMEOUT_CYC=4) on the second instance
        @(negedge clk);
        rd1 = 1; f31 = F3_LW; ad1 = 32'h40;
        @(negedge clk); #1;
        b1.mem_gnt_i = 1; b1.mem_rvalid_i = 1;
        b1.mem_rdata_i = 32'h11112222;
        @(negedge clk); #1;
        b1.mem_gnt_i = 0; b1.mem_rvalid_i = 0;
        rd1 = 0;
        chk("wd_prime_data", data1, 32'h11112222);
        @(negedge clk);
        rd1 = 1; ad1 = 32'h44;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); #1;
            b1.mem_gnt_i = (k == 1);
            chk($sformatf("wd_err_cyc%0d", k), {31'h0, err1},
                (k == 4) ? 32'd1 : 32'd0);
        end
        chk("wd_stall_last", {31'h0, stall1}, 1);
        @(negedge clk); #1;
        b1.mem_gnt_i = 0;
        chk("wd_done_stall", {31'h0, stall1}, 0);
        chk("wd_done_err", {31'h0, err1}, 0);
        chk("wd_data_zero", data1, 0);
        rd1 = 0;

        // asynchronous reset while waiting for rvalid
        @(negedge clk);
        rd0 = 1; f30 = F3_LW; ad0 = 32'h80;
        @(negedge clk); #1;
        b0.mem_gnt_i = 1;
        @(negedge clk); #1;
        b0.mem_gnt_i = 0;
        rd0 = 0;
        chk("arst_wait_stall", {31'h0, stall0}, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_stall", {31'h0, stall0}, 0);
        chk("arst_addr", b0.mem_addr_o, 0);
        chk("arst_be", {28'h0, b0.mem_be_o}, 0);
        chk("arst_wdata", b0.mem_wdata_o, 0);
        chk("arst_we", {31'h0, b0.mem_we_o}, 0);
        chk("arst_data", data0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        b0.mem_rvalid_i = 1; b0.mem_rdata_i = 32'hFFFFFFFF;
        @(negedge clk); #1;
        b0.mem_rvalid_i = 0;
        chk("arst_stale_data", data0, 0);
        chk("arst_stale_stall", {31'h0, stall0}, 0);
        chk("arst_stale_req", {31'h0, b0.mem_req_o}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-stage load/store unit between the EX/MEM pipeline register and the MEM/WB register.
- Takes the EX/MEM access request (ALU result as address, rs2 store data, funct3 size) and runs it on a data-memory bus with a req/gnt/rvalid handshake.
- Stalls the pipeline until the access completes.
- Delivers aligned, sign/zero-extended load data on data_o, which feeds the MEM/WB data input.

Parameters:
- TIMEOUT_CYC, 255: max cycles in REQ or WAIT before bus_err_o; 0 disables the watchdog.
- Data and address width are fixed at 32 bits; they are not parameters.

Ports:
- clk  in  1  pipeline clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- MemRead_i  in  1  load request from EX/MEM.
- MemWrite_i  in  1  store request from EX/MEM.
- funct3_i  in  3  access size/sign (RV32I encoding).
- addr_i  in  32  byte address (EX/MEM ALUResult).
- wdata_i  in  32  store data (rs2).
- flush_i  in  1  squash the current access (trap/redirect).
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}.
- mem_wdata_o  out  32  lane-replicated store data.
- mem_be_o  out  4  byte enables.
- mem_gnt_i  in  1  request accepted.
- mem_rvalid_i  in  1  response/ack (loads and stores).
- mem_rdata_i  in  32  read word.
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
- data_o  out  32  formatted load data to MEM/WB.
- misalign_o  out  1  misaligned access flag (combinational).
- bus_err_o  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
Reset (async, rst_n=0):
- state=IDLE.
- mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, mem_be_o=0.
- data_o=0, bus_err_o=0, watchdog counter=0.
- Reset mid-transaction abandons it; outstanding bus responses are ignored after reset.

Access valid (acc): (MemRead_i|MemWrite_i) & !flush_i.
- If both MemRead_i and MemWrite_i are 1, the access is a load.

Misaligned:
- Halfword (funct3[1:0]=01) with addr[0]=1, or word (1x) with addr[1:0]!=0.
- In IDLE, misalign_o=acc&misaligned; no bus activity, no stall, data_o unchanged.
- funct3 011/110/111 are treated as word size.

States:
- IDLE: stall_o=acc&!misaligned. On that condition, register addr, be, wdata, we, funct3 and go to REQ.
- REQ: mem_req_o=1, stall_o=1. Outputs stay stable until gnt.
  - gnt&rvalid same cycle: capture, go to DONE.
  - gnt only: go to WAIT.
  - flush_i without gnt: go to IDLE with no capture.
- WAIT: stall_o=1, mem_req_o=0. On rvalid go to DONE. flush_i is ignored here; the transaction always completes.
- DONE: stall_o=0 for exactly one cycle so the pipeline advances; next state is IDLE.
  - DONE is entered even if flush occurred during WAIT, but data_o is not updated in that case.

Capture:
- Loads only. data_o <= formatted mem_rdata_i at the rvalid edge; held until the next load capture.

Store lanes:
- SB: be=4'b0001<<addr[1:0]; wdata={4{wdata_i[7:0]}}.
- SH: be=4'b0011<<{addr[1],1'b0}; wdata={2{wdata_i[15:0]}}.
- SW: be=4'b1111.
- Loads drive be=4'b1111.

Load format:
- Select byte addr[1:0] or half addr[1].
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.

Latency:
- Minimum 2 stall cycles (IDLE, REQ with gnt+rvalid).
- Each gnt or rvalid wait cycle adds one.

Watchdog:
- Counter resets on entering REQ and increments in REQ/WAIT.
- At TIMEOUT_CYC: bus_err_o pulses, data_o=0 for loads, go to DONE.

Decomposition:
- Package mem_lsu_pkg holds:
  - funct3 constants (F3_LB=3'b000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101).
  - State enum {IDLE, REQ, WAIT, DONE} (2 bits).
- Sub-module lsu_align (combinational) builds mem_be/mem_wdata for stores and the formatted load value from rdata, addr[1:0] and funct3.

Test Plan:
1. LW addr=0x100; memory returns 0xDEADBEEF with gnt+rvalid same cycle as req -> mem_addr_o=0x100, be=1111, stall_o high 2 cycles then low 1 cycle, data_o=0xDEADBEEF.
2. LB addr=0x103, rdata=0x80FF_1234 -> data_o=0xFFFFFF80. LBU at the same address -> data_o=0x00000080. LHU addr=0x102 -> data_o=0x000080FF.
3. SH addr=0x206, wdata_i=0x1234ABCD -> mem_we_o=1, mem_addr_o=0x204, be=1100, mem_wdata_o=0xABCDABCD, data_o unchanged.
4. Handshake delays: gnt withheld 3 cycles, rvalid 2 cycles after gnt -> req held stable 4 cycles, stall_o high 7 cycles total, single DONE cycle.
5. Misaligned LW addr=0x102 -> misalign_o=1 same cycle, mem_req_o never asserts, stall_o=0. Then flush_i in REQ before gnt -> return to IDLE, no DONE.
6. TIMEOUT_CYC=4, rvalid never arrives -> bus_err_o pulse on the 4th REQ/WAIT cycle, data_o=0. Separately, rst_n low during WAIT -> all outputs 0 immediately, state IDLE.
